// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer
// Brief    : Loadable multi-digit BCD down-counter with run/pause/expire FSM.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] preset,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                done,
  output logic                busy,
  output logic                err
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_RUN     = 2'd1;
  localparam logic [1:0] c_ST_PAUSED  = 2'd2;
  localparam logic [1:0] c_ST_EXPIRED = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [4*DIGITS-1:0] r_count;
  logic [4*DIGITS-1:0] w_count_nxt;
  logic [4*DIGITS-1:0] w_count_dec;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic [DIGITS-1:0]   w_borrow;
  logic [DIGITS-1:0]   w_digit_ok;
  logic                w_preset_ok;
  logic                w_count_zero;
  logic                w_dec_zero;

  // Per-digit mod-10 decrement; borrow ripples upward through zero digits.
  assign w_borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_dig;
    logic       w_dig_zero;

    assign w_dig         = r_count[4*i +: 4];
    assign w_dig_zero    = (w_dig == 4'd0);
    assign w_digit_ok[i] = (preset[4*i +: 4] <= 4'd9);
    assign w_count_dec[4*i +: 4] = !w_borrow[i] ? w_dig :
                                   (w_dig_zero ? 4'd9 : w_dig - 4'd1);

    if (i < DIGITS - 1) begin : g_borrow
      assign w_borrow[i+1] = w_borrow[i] & w_dig_zero;
    end
  end

  assign w_preset_ok  = &w_digit_ok;
  assign w_count_zero = (r_count == '0);
  assign w_dec_zero   = (w_count_dec == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Any load request, valid or not, consumes the edge.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    if (load) begin
      if (w_preset_ok) begin
        w_count_nxt = preset;
        w_state_nxt = c_ST_IDLE;
        w_err_nxt   = 1'b0;
      end else begin
        w_err_nxt   = 1'b1;
      end
    end else if (start && (r_state == c_ST_IDLE || r_state == c_ST_PAUSED)) begin
      if (w_count_zero) begin
        w_state_nxt = c_ST_EXPIRED;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = c_ST_RUN;
      end
    end else if (pause && r_state == c_ST_RUN) begin
      w_state_nxt = c_ST_PAUSED;
    end else if (tick && r_state == c_ST_RUN && !w_count_zero) begin
      w_count_nxt = w_count_dec;
      if (w_dec_zero) begin
        w_state_nxt = c_ST_EXPIRED;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_comb begin
    busy  = (r_state == c_ST_RUN) || (r_state == c_ST_PAUSED);
    count = r_count;
    zero  = w_count_zero;
    done  = r_done;
    err   = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown_timer
// Brief    : Directed self-checking bench for bcd_countdown_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, start, pause, tick;
  logic [7:0]  preset;
  logic [7:0]  count;
  logic        zero, done, busy, err;

  logic        load3, start3, pause3, tick3;
  logic [11:0] preset3;
  logic [11:0] count3;
  logic        zero3, done3, busy3, err3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(2)) dut (
    .clk(clk), .rst(rst), .load(load), .preset(preset), .start(start),
    .pause(pause), .tick(tick), .count(count), .zero(zero), .done(done),
    .busy(busy), .err(err)
  );

  bcd_countdown_timer #(.DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .load(load3), .preset(preset3), .start(start3),
    .pause(pause3), .tick(tick3), .count(count3), .zero(zero3), .done(done3),
    .busy(busy3), .err(err3)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    preset = v; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 0; start = 0; pause = 0; tick = 0; preset = 8'h00;
    load3 = 0; start3 = 0; pause3 = 0; tick3 = 0; preset3 = 12'h000;
    #2;
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL por_count: got %h want 00", count); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL por_zero: got %b want 1", zero); end
    @(negedge clk); rst = 1'b1;
    cycle();
    checks++; if (count !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL release: count=%h busy=%b done=%b want 00/0/0", count, busy, done); end
    do_load(8'h37);
    do_start();
    checks++; if (count !== 8'h37 || busy !== 1'b1) begin
      errors++; $display("FAIL run37: count=%h busy=%b want 37/1", count, busy); end
    do_load(8'h3F);
    checks++; if (count !== 8'h37 || err !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL bad_load_in_run: count=%h err=%b busy=%b want 37/1/1", count, err, busy); end
    #3; rst = 1'b0; #1;
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL async_count: got %h want 00", count); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL async_zero: got %b want 1", zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err: got %b want 0", err); end
    #2; rst = 1'b1;
    cycle();
    checks++; if (count !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset: count=%h busy=%b want 00/0", count, busy); end
  endtask

  task automatic test_countdown();
    logic [7:0] exp;
    do_load(8'h12);
    checks++; if (count !== 8'h12 || busy !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL cd_load: count=%h busy=%b zero=%b want 12/0/0", count, busy, zero); end
    do_start();
    checks++; if (count !== 8'h12 || busy !== 1'b1) begin
      errors++; $display("FAIL cd_start: count=%h busy=%b want 12/1", count, busy); end
    tick = 1'b1;
    for (int n = 11; n >= 0; n--) begin
      cycle();
      exp = 8'((n / 10) * 16 + (n % 10));
      checks++; if (count !== exp) begin errors++; $display("FAIL cd_count: got %h want %h", count, exp); end
      checks++; if (done !== (n == 0)) begin errors++; $display("FAIL cd_done at %h: got %b want %b", exp, done, (n == 0)); end
      if (n == 0) begin
        checks++; if (busy !== 1'b0 || zero !== 1'b1) begin
          errors++; $display("FAIL cd_expired: busy=%b zero=%b want 0/1", busy, zero); end
      end
    end
    cycle();
    checks++; if (done !== 1'b0 || count !== 8'h00) begin
      errors++; $display("FAIL cd_after: done=%b count=%h want 0/00", done, count); end
    tick = 1'b0;
  endtask

  task automatic test_pause();
    do_load(8'h05);
    do_start();
    tick = 1'b1; cycle();
    checks++; if (count !== 8'h04) begin errors++; $display("FAIL pz_t1: got %h want 04", count); end
    tick = 1'b0; cycle();
    checks++; if (count !== 8'h04) begin errors++; $display("FAIL pz_gap: got %h want 04", count); end
    tick = 1'b1; cycle();
    checks++; if (count !== 8'h03) begin errors++; $display("FAIL pz_t2: got %h want 03", count); end
    pause = 1'b1; cycle();
    pause = 1'b0;
    checks++; if (count !== 8'h03 || busy !== 1'b1) begin
      errors++; $display("FAIL pz_pause: count=%h busy=%b want 03/1", count, busy); end
    cycle(); cycle();
    checks++; if (count !== 8'h03) begin errors++; $display("FAIL pz_hold: got %h want 03", count); end
    tick = 1'b0;
    do_start();
    checks++; if (count !== 8'h03 || busy !== 1'b1) begin
      errors++; $display("FAIL pz_resume: count=%h busy=%b want 03/1", count, busy); end
    tick = 1'b1; cycle();
    checks++; if (count !== 8'h02 || done !== 1'b0) begin
      errors++; $display("FAIL pz_r1: count=%h done=%b want 02/0", count, done); end
    cycle();
    checks++; if (count !== 8'h01 || done !== 1'b0) begin
      errors++; $display("FAIL pz_r2: count=%h done=%b want 01/0", count, done); end
    cycle();
    checks++; if (count !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL pz_expire: count=%h done=%b busy=%b want 00/1/0", count, done, busy); end
    tick = 1'b0;
  endtask

  task automatic test_invalid_load();
    do_load(8'h42);
    checks++; if (count !== 8'h42 || err !== 1'b0) begin
      errors++; $display("FAIL inv_setup: count=%h err=%b want 42/0", count, err); end
    do_load(8'h1A);
    checks++; if (count !== 8'h42 || err !== 1'b1) begin
      errors++; $display("FAIL inv_bad: count=%h err=%b want 42/1", count, err); end
    cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv_sticky: got %b want 1", err); end
    do_load(8'h07);
    checks++; if (count !== 8'h07 || err !== 1'b0) begin
      errors++; $display("FAIL inv_good: count=%h err=%b want 07/0", count, err); end
  endtask

  task automatic test_start_zero();
    do_load(8'h00);
    do_start();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || count !== 8'h00) begin
      errors++; $display("FAIL sz_pulse: done=%b busy=%b count=%h want 1/0/00", done, busy, count); end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sz_clear: got %b want 0", done); end
    start = 1'b1; tick = 1'b1; cycle();
    start = 1'b0; tick = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || count !== 8'h00) begin
      errors++; $display("FAIL sz_restart: done=%b busy=%b count=%h want 0/0/00", done, busy, count); end
  endtask

  task automatic test_simultaneous();
    do_load(8'h20);
    do_start();
    load = 1'b1; start = 1'b1; preset = 8'h99; cycle();
    load = 1'b0; start = 1'b0;
    checks++; if (count !== 8'h99 || busy !== 1'b0) begin
      errors++; $display("FAIL sim_load_wins: count=%h busy=%b want 99/0", count, busy); end
    do_load(8'h50);
    do_start();
    pause = 1'b1; tick = 1'b1; cycle();
    pause = 1'b0; tick = 1'b0;
    checks++; if (count !== 8'h50 || busy !== 1'b1) begin
      errors++; $display("FAIL sim_pause_tick: count=%h busy=%b want 50/1", count, busy); end
    start = 1'b1; tick = 1'b1; cycle();
    start = 1'b0;
    checks++; if (count !== 8'h50) begin errors++; $display("FAIL sim_start_tick: got %h want 50", count); end
    cycle();
    tick = 1'b0;
    checks++; if (count !== 8'h49) begin errors++; $display("FAIL sim_borrow: got %h want 49", count); end
  endtask

  task automatic test_three_digit();
    preset3 = 12'h100; load3 = 1'b1; cycle(); load3 = 1'b0;
    start3 = 1'b1; cycle(); start3 = 1'b0;
    tick3 = 1'b1; cycle();
    checks++; if (count3 !== 12'h099) begin errors++; $display("FAIL d3_borrow: got %h want 099", count3); end
    cycle();
    tick3 = 1'b0;
    checks++; if (count3 !== 12'h098 || busy3 !== 1'b1 || err3 !== 1'b0) begin
      errors++; $display("FAIL d3_next: count=%h busy=%b err=%b want 098/1/0", count3, busy3, err3); end
    checks++; if (done3 !== 1'b0 || zero3 !== 1'b0) begin
      errors++; $display("FAIL d3_flags: done=%b zero=%b want 0/0", done3, zero3); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_invalid_load();
    test_start_zero();
    test_simultaneous();
    test_three_digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
